// File: rtl/bp_fe_icache_mem_responder.sv
// BedRock stream memory endpoint for the I$ unit bench: latched cmd, fixed
// latency, critical-word-first resp beats, word store with per-word valid bits.
// Ports: clk_i/reset_i; mem_cmd_{header,data,v,last}_i + mem_cmd_ready_and_o;
//        mem_resp_{header,data,v,last}_o + mem_resp_ready_and_i.
package bp_fe_icache_mem_responder_pkg;
  localparam int paddr_width_p   = 40;
  localparam int did_width_p     = 3;
  localparam int lce_id_width_p  = 4;
  localparam int lce_assoc_p     = 8;
  localparam int l2_data_width_p = 64;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bp_bedrock_mem_type_e;

  typedef struct packed {
    logic [did_width_p-1:0]         did;
    logic [lce_id_width_p-1:0]      lce_id;
    logic [$clog2(lce_assoc_p)-1:0] way_id;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_payload_s  payload;
    logic [2:0]               size;
    logic [paddr_width_p-1:0] addr;
    bp_bedrock_mem_type_e     msg_type;
  } bp_bedrock_mem_header_s;
endpackage

module bp_fe_icache_mem_responder
  import bp_fe_icache_mem_responder_pkg::*;
#(
  parameter int mem_els_p = 1024,
  parameter int latency_p = 4,
  localparam int mem_header_width_lp = $bits(bp_bedrock_mem_header_s),
  localparam int word_bytes_lp = l2_data_width_p / 8
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [mem_header_width_lp-1:0] mem_cmd_header_i,
  input  logic [l2_data_width_p-1:0]     mem_cmd_data_i,
  input  logic                           mem_cmd_v_i,
  output logic                           mem_cmd_ready_and_o,
  input  logic                           mem_cmd_last_i,
  output logic [mem_header_width_lp-1:0] mem_resp_header_o,
  output logic [l2_data_width_p-1:0]     mem_resp_data_o,
  output logic                           mem_resp_v_o,
  input  logic                           mem_resp_ready_and_i,
  output logic                           mem_resp_last_o
);

  localparam int LG_WB  = $clog2(word_bytes_lp);
  localparam int LG_L2  = $clog2(l2_data_width_p);
  localparam int LG_ELS = $clog2(mem_els_p);
  localparam int WA     = paddr_width_p - LG_WB;

  typedef enum logic [1:0] {
    e_ready, e_cmd_data, e_wait, e_resp
  } state_e;

  // log2 of the beat count; sub-word sizes collapse to one beat
  function automatic int f_lgn(input logic [2:0] sz);
    int n;
    n = int'(sz) + 3 - LG_L2;
    return (n < 0) ? 0 : n;
  endfunction

  function automatic logic [7:0] f_nbeats(input logic [2:0] sz);
    return 8'(1 << f_lgn(sz));
  endfunction

  // word address of beat i: wraps inside the N-word aligned block
  function automatic logic [WA-1:0] f_waddr(
    input logic [paddr_width_p-1:0] a,
    input logic [2:0]               sz,
    input logic [7:0]               i
  );
    logic [WA-1:0] w, m;
    w = a[paddr_width_p-1:LG_WB];
    m = (WA'(1) << f_lgn(sz)) - WA'(1);
    return (w & ~m) | ((w + WA'(i)) & m);
  endfunction

  state_e                 r_state;
  bp_bedrock_mem_header_s r_hdr;
  logic                   r_wr;
  logic [7:0]             r_beat;
  logic [7:0]             r_ncmd;
  logic [7:0]             r_nresp;
  logic [7:0]             r_cnt;
  logic [mem_els_p-1:0]   r_vld;
  logic [l2_data_width_p-1:0] r_mem [mem_els_p];

  bp_bedrock_mem_header_s w_cmd_hdr;
  logic                   w_cmd_wr;
  logic                   w_cmd_hs;
  logic                   w_resp_act;
  logic                   w_resp_hs;
  logic                   w_wr_en;
  logic [LG_ELS-1:0]      w_wr_idx;
  logic [WA-1:0]          w_rd_waddr;
  logic [LG_ELS-1:0]      w_rd_idx;
  logic [l2_data_width_p-1:0] w_rd_word;

  assign w_cmd_hdr = mem_cmd_header_i;
  assign w_cmd_wr  = (w_cmd_hdr.msg_type == e_bedrock_mem_wr)
                   | (w_cmd_hdr.msg_type == e_bedrock_mem_uc_wr);

  assign mem_cmd_ready_and_o = ~reset_i
    & ((r_state == e_ready) | (r_state == e_cmd_data));
  assign w_cmd_hs = mem_cmd_v_i & mem_cmd_ready_and_o;

  assign w_resp_act = ~reset_i & (r_state == e_resp);
  assign w_resp_hs  = w_resp_act & mem_resp_ready_and_i;

  assign w_wr_en = w_cmd_hs
    & (((r_state == e_ready) & w_cmd_wr) | (r_state == e_cmd_data));
  // beat 0 arrives with the header, so its address comes off the port
  assign w_wr_idx = (r_state == e_ready)
    ? LG_ELS'(f_waddr(w_cmd_hdr.addr, w_cmd_hdr.size, 8'd0))
    : LG_ELS'(f_waddr(r_hdr.addr, r_hdr.size, r_beat));

  assign w_rd_waddr = f_waddr(r_hdr.addr, r_hdr.size, r_beat);
  assign w_rd_idx   = w_rd_waddr[LG_ELS-1:0];
  assign w_rd_word  = r_vld[w_rd_idx] ? r_mem[w_rd_idx]
    : l2_data_width_p'({w_rd_waddr, {LG_WB{1'b0}}});

  assign mem_resp_v_o      = w_resp_act;
  assign mem_resp_last_o   = w_resp_act & (r_beat == r_nresp - 8'd1);
  assign mem_resp_header_o = w_resp_act ? r_hdr : '0;
  assign mem_resp_data_o   = (w_resp_act & ~r_wr) ? w_rd_word : '0;

  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[w_wr_idx] <= mem_cmd_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= e_ready;
      r_hdr   <= '0;
      r_wr    <= 1'b0;
      r_beat  <= '0;
      r_ncmd  <= '0;
      r_nresp <= '0;
      r_cnt   <= '0;
      r_vld   <= '0;
    end else begin
      unique case (r_state)
        e_ready: if (w_cmd_hs) begin
          r_hdr   <= w_cmd_hdr;
          r_wr    <= w_cmd_wr;
          r_ncmd  <= f_nbeats(w_cmd_hdr.size);
          r_nresp <= w_cmd_wr ? 8'd1 : f_nbeats(w_cmd_hdr.size);
          r_beat  <= '0;
          r_cnt   <= 8'(latency_p - 1);
          if (w_cmd_wr & ~mem_cmd_last_i) begin
            r_beat  <= 8'd1;
            r_state <= e_cmd_data;
          end else begin
            r_state <= (latency_p == 1) ? e_resp : e_wait;
          end
        end
        e_cmd_data: if (w_cmd_hs) begin
          if (mem_cmd_last_i) begin
            r_beat  <= '0;
            r_cnt   <= 8'(latency_p - 1);
            r_state <= (latency_p == 1) ? e_resp : e_wait;
          end else begin
            r_beat <= r_beat + 8'd1;
          end
        end
        e_wait: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) r_state <= e_resp;
        end
        e_resp: if (w_resp_hs) begin
          if (r_beat == r_nresp - 8'd1) begin
            r_beat  <= '0;
            r_state <= e_ready;
          end else begin
            r_beat <= r_beat + 8'd1;
          end
        end
        default: r_state <= e_ready;
      endcase
      if (w_wr_en) r_vld[w_wr_idx] <= 1'b1;
    end
  end

  always @(posedge clk_i) begin
    if (!reset_i && w_cmd_hs) begin
      if (r_state == e_ready) begin
        assert (w_cmd_hdr.msg_type inside {e_bedrock_mem_rd,
          e_bedrock_mem_wr, e_bedrock_mem_uc_rd, e_bedrock_mem_uc_wr});
        if (!w_cmd_wr) assert (mem_cmd_last_i);
        if (w_cmd_wr && mem_cmd_last_i)
          assert (f_nbeats(w_cmd_hdr.size) == 8'd1);
      end
      if (r_state == e_cmd_data) begin
        if (mem_cmd_last_i) assert (r_beat + 8'd1 == r_ncmd);
        else assert (r_beat + 8'd1 < r_ncmd);
      end
    end
  end

endmodule
